// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, counter sizing and defaults for the FIFO arbiters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEFAULT_MAXBEAT = 16;

  // Smallest width w with 2**w >= value; used to size the beat counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set request after last_gnt
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_gnt,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int w_best;
    int w_dist;
    any    = 1'b0;
    idx    = '0;
    w_best = NREQ;
    w_dist = 0;
    // Distance 0 is the requester right after last_gnt, so the lowest distance wins.
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 1 - int'(last_gnt)) % NREQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = IDW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-atomic round-robin sharing of the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAXBEAT = DEFAULT_MAXBEAT
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  input  logic                  err_clr,
  output logic                  overflow_err
);

  localparam int CW = clog2(MAXBEAT + 1);
  // Comparing against MAXBEAT-1 before the increment keeps the counter from ever reaching MAXBEAT.
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBEAT - 1);

  arb_state_t       r_state;
  logic [IDW-1:0]   r_last_gnt;
  logic [IDW-1:0]   r_grant_id;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_busy;
  logic             r_overflow_err;

  logic             w_pick_any;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_in_burst;
  logic             w_accept;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req      (req_valid),
    .last_gnt (r_last_gnt),
    .any      (w_pick_any),
    .idx      (w_pick_idx)
  );

  assign w_in_burst = (r_state == BURST);
  assign w_accept   = w_in_burst & w_sel_valid & ~wfull;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_sel_valid  = req_valid[i];
        w_sel_last   = req_last[i];
        w_sel_data   = req_data[i*DSIZE +: DSIZE];
        req_ready[i] = w_in_burst & ~wfull;
      end
    end
  end

  assign winc         = w_accept;
  assign wdata        = w_in_burst ? w_sel_data : '0;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign overflow_err = r_overflow_err;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state        <= IDLE;
      r_last_gnt     <= IDW'(NREQ - 1);
      r_grant_id     <= '0;
      r_beat_cnt     <= '0;
      r_busy         <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      if (err_clr) begin
        r_overflow_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            if (w_sel_last || (r_beat_cnt == LAST_BEAT)) begin
              // A new overflow overrides a same-cycle clear.
              if (!w_sel_last) begin
                r_overflow_err <= 1'b1;
              end
              r_state    <= IDLE;
              r_last_gnt <= r_grant_id;
              r_beat_cnt <= '0;
              r_busy     <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench with a packet-level arbitration model
module tb_fifo_wr_arbiter;

  localparam int DSIZE   = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MAXBEAT = 16;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  err_clr;
  logic                  overflow_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    int               id;
    logic [DSIZE-1:0] data;
    bit               first;
  } exp_t;

  typedef struct {
    int               id;
    logic [DSIZE-1:0] data;
    int               cyc;
  } obs_t;

  beat_t rq[NREQ][$];
  exp_t  exp_q[$];
  obs_t  obs_q[$];

  fifo_wr_arbiter #(
    .DSIZE   (DSIZE),
    .NREQ    (NREQ),
    .IDW     (IDW),
    .MAXBEAT (MAXBEAT)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .wfull        (wfull),
    .winc         (winc),
    .wdata        (wdata),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_clr      (err_clr),
    .overflow_err (overflow_err)
  );

  always #5 wclk = ~wclk;

  task automatic do_reset();
    @(negedge wclk);
    wrst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(negedge wclk);
    wrst = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
  endtask

  // base < 0 gives random data, otherwise base, base+1, ...
  task automatic add_packet(input int id, input int len, input int base, input bit with_last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = (base < 0) ? DSIZE'($urandom) : DSIZE'(base + k);
      b.last = with_last && (k == len - 1);
      rq[id].push_back(b);
    end
  endtask

  // Packet-level model: round robin over requesters that still hold beats, starting after
  // requester NREQ-1; a packet ends at its last beat, at MAXBEAT beats, or when beats run out.
  task automatic build_expected();
    beat_t mq[NREQ][$];
    beat_t b;
    int    last_id;
    int    pick;
    int    n;
    bit    done;
    bit    stop;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    last_id = NREQ - 1;
    done    = 1'b0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && mq[(last_id + k) % NREQ].size() > 0) pick = (last_id + k) % NREQ;
      end
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        n    = 0;
        stop = 1'b0;
        while (!stop && mq[pick].size() > 0 && n < MAXBEAT) begin
          b = mq[pick].pop_front();
          exp_q.push_back('{id: pick, data: b.data, first: (n == 0)});
          n++;
          if (b.last) stop = 1'b1;
        end
        last_id = pick;
      end
    end
  endtask

  task automatic run(input int full_pct, input int gap_pct, input int full_at, input int full_len,
                     input int gap_req, input int gap_at, input int gap_len,
                     input bit chk_spacing, input string name);
    int              cyc;
    int              acc_total;
    int              full_left;
    int              gap_left;
    int              pending;
    bit              full_done;
    bit              gap_done;
    bit              drop;
    int              acc_cnt[NREQ];
    bit              in_pkt[NREQ];
    logic [NREQ-1:0] acc;
    int              step;
    build_expected();
    obs_q.delete();
    cyc = 0; acc_total = 0; full_left = 0; gap_left = 0; pending = 0;
    full_done = 1'b0; gap_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      acc_cnt[i] = 0;
      in_pkt[i]  = 1'b0;
      pending    = pending + rq[i].size();
    end
    while (pending > 0 && cyc < 4000) begin
      @(negedge wclk);
      if (!full_done && acc_total == full_at) begin
        full_left = full_len;
        full_done = 1'b1;
      end
      wfull = (full_left > 0) || (int'($urandom_range(99)) < full_pct);
      if (full_left > 0) full_left--;
      if (!gap_done && gap_req >= 0 && acc_cnt[gap_req] == gap_at) begin
        gap_left = gap_len;
        gap_done = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        drop = in_pkt[i] && (int'($urandom_range(99)) < gap_pct);
        if (i == gap_req && gap_left > 0) drop = 1'b1;
        req_valid[i]                = (rq[i].size() > 0) && !drop;
        req_data[i*DSIZE +: DSIZE]  = (rq[i].size() > 0) ? rq[i][0].data : '0;
        req_last[i]                 = (rq[i].size() > 0) && rq[i][0].last;
      end
      if (gap_left > 0) gap_left--;
      #1;
      acc = req_valid & req_ready;
      checks++;
      if (winc !== (|acc)) begin
        errors++;
        $display("FAIL %s winc_vs_handshake cyc=%0d: winc=%b required=%b", name, cyc, winc, |acc);
      end
      checks++;
      if ($countones(req_ready) > 1 || (wfull && req_ready != '0)) begin
        errors++;
        $display("FAIL %s req_ready cyc=%0d: got %b with wfull=%b, required at most one bit and none when full",
                 name, cyc, req_ready, wfull);
      end
      if (winc === 1'b1) obs_q.push_back('{id: int'(grant_id), data: wdata, cyc: cyc});
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          in_pkt[i] = !rq[i][0].last;
          acc_cnt[i]++;
          acc_total++;
          pending--;
          void'(rq[i].pop_front());
        end
      end
      cyc++;
    end
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d beats still pending, required 0", name, pending);
    end
    @(negedge wclk);
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== exp_q[k].data) begin
        errors++;
        $display("FAIL %s beat[%0d]: got id=%0d data=%h required id=%0d data=%h",
                 name, k, obs_q[k].id, obs_q[k].data, exp_q[k].id, exp_q[k].data);
      end
      if (chk_spacing && k > 0) begin
        step = exp_q[k].first ? 2 : 1;
        checks++;
        if (obs_q[k].cyc - obs_q[k-1].cyc != step) begin
          errors++;
          $display("FAIL %s spacing[%0d]: got %0d cycles required %0d",
                   name, k, obs_q[k].cyc - obs_q[k-1].cyc, step);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [DSIZE-1:0] d0;
    @(negedge wclk);
    wrst      = 1'b1;
    req_valid = '1;
    req_last  = '0;
    req_data  = NREQ*DSIZE'($urandom);
    wfull     = 1'b0;
    err_clr   = 1'b0;
    d0        = req_data[DSIZE-1:0];
    repeat (2) @(negedge wclk);
    #1;
    checks++;
    if (winc !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== '0 ||
        overflow_err !== 1'b0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: winc=%b ready=%b busy=%b gid=%0d oerr=%b wdata=%h, required all zero",
               winc, req_ready, busy, grant_id, overflow_err, wdata);
    end
    @(negedge wclk);
    wrst = 1'b0;
    @(negedge wclk);
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== '0 || winc !== 1'b1 || wdata !== d0) begin
      errors++;
      $display("FAIL reset_first_grant: busy=%b gid=%0d winc=%b wdata=%h, required 1 0 1 %h",
               busy, grant_id, winc, wdata, d0);
    end
    @(negedge wclk);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) add_packet(i, 3, -1, 1'b1);
    end
    run(0, 0, -1, 0, -1, 0, 0, 1'b1, "round_robin");
  endtask

  task automatic test_backpressure();
    do_reset();
    add_packet(2, 5, 'hA0, 1'b1);
    add_packet(3, 2, -1, 1'b1);
    run(0, 0, 2, 4, -1, 0, 0, 1'b0, "backpressure");
  endtask

  task automatic test_gap();
    do_reset();
    add_packet(1, 5, 'h10, 1'b1);
    add_packet(3, 3, 'h30, 1'b1);
    run(0, 0, -1, 0, 1, 1, 3, 1'b0, "gap");
  endtask

  task automatic test_overflow();
    do_reset();
    add_packet(0, MAXBEAT + 4, 'h40, 1'b0);
    run(0, 0, -1, 0, -1, 0, 0, 1'b0, "overflow");
    #1;
    checks++;
    if (overflow_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: oerr=%b busy=%b, required 1 1", overflow_err, busy);
    end
    repeat (3) @(negedge wclk);
    #1;
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", overflow_err);
    end
    @(negedge wclk);
    err_clr = 1'b1;
    @(negedge wclk);
    err_clr = 1'b0;
    #1;
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b required 0", overflow_err);
    end
  endtask

  task automatic test_err_collision();
    do_reset();
    add_packet(0, MAXBEAT, -1, 1'b0);
    err_clr = 1'b1;
    run(0, 0, -1, 0, -1, 0, 0, 1'b0, "err_collision");
    #1;
    checks++;
    if (overflow_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_collision_set: oerr=%b busy=%b, required 1 0", overflow_err, busy);
    end
    @(negedge wclk);
    #1;
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL err_collision_clear: got %b required 0", overflow_err);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int beats;
    int guard;
    do_reset();
    beats = 0;
    guard = 0;
    while (beats < 2 && guard < 50) begin
      @(negedge wclk);
      req_valid                  = 4'b0100;
      req_last                   = '0;
      req_data[2*DSIZE +: DSIZE] = DSIZE'('h60 + beats);
      #1;
      if (winc === 1'b1) beats++;
      guard++;
    end
    checks++;
    if (beats != 2) begin
      errors++;
      $display("FAIL reset_mid_beats: got %0d beats required 2", beats);
    end
    @(negedge wclk);
    wrst      = 1'b1;
    req_valid = '1;
    @(negedge wclk);
    #1;
    checks++;
    if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_mid_idle: winc=%b busy=%b ready=%b, required 0 0 0", winc, busy, req_ready);
    end
    wrst = 1'b0;
    @(negedge wclk);
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== '0) begin
      errors++;
      $display("FAIL reset_mid_regrant: busy=%b gid=%0d, required 1 0", busy, grant_id);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        for (int p = 0; p < int'($urandom_range(3)); p++) begin
          add_packet(i, int'($urandom_range(MAXBEAT, 1)), -1, 1'b1);
        end
      end
      run(30, 20, -1, 0, -1, 0, 0, 1'b0, "random");
    end
  endtask

  initial begin
    wrst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_gap();
    test_overflow();
    test_err_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
